clear_redraw: RTL and testbench
===============================

CLEAR_REDRAW -- requirements
Module: clear_redraw

Interface
REQ-001 SHALL have a single clock and a reset that is asynchronous and active-low.
REQ-002 SHALL provide port `clka`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port `restart_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL provide port `state`: input, 3 bits, game FSM state from the controller: 000 GEN, 001 MOVE, 011 CLEAR; other codes are hold.
REQ-005 SHALL provide port `board_in`: input, 32 bits, landed board snapshot, sampled in CLEAR only.
REQ-006 SHALL provide port `curr_piece`: input, 2 bits, piece to spawn, sampled in GEN only.
REQ-007 SHALL provide port `board_out`: output, 32 bits, registered board.
REQ-008 SHALL provide port `error`: output, 1 bit, registered sticky spawn-collision (game-over) flag.

Function
REQ-009 Board SHALL be 8 rows x 4 columns.
- Row r = bits [31-4r : 28-4r].
- Row 0 = [31:28] is the bottom; row 7 = [3:0] is the top.
- Spawn zone = rows 6-7 = bits [7:0].
REQ-010 In CLEAR, the internal board SHALL load compact(board_in) at the next edge.
- compact removes every full row (nibble 4'hF).
- Surviving rows drop toward row 0 in their original order.
- Vacated top rows are filled with 4'h0.
- Any number of full rows, 0 to 8, SHALL be handled in one cycle.
REQ-011 In GEN, piece masks over bits [7:0] SHALL be: 00 -> 8'h06, 01 -> 8'h66, 10 -> 8'h46, 11 -> 8'h63.
REQ-012 In GEN with (board & mask) == 0 and error == 0, the board SHALL become board | mask at the next edge.
REQ-013 In GEN with (board & mask) != 0, error SHALL be set to 1 and the board SHALL be left unchanged.
REQ-014 While error == 1, GEN SHALL not modify the board; CLEAR still operates.
REQ-015 MOVE and undefined state codes SHALL hold the board and error unchanged.
REQ-016 board_out SHALL equal the internal board register: one-cycle latency, no combinational path from any input to any output.
REQ-017 error SHALL remain 1 until reset.

Reset
REQ-018 Asserting restart_n low SHALL immediately force board_out = 32'h0 and error = 0, including mid-operation.
REQ-019 While restart_n is low, state inputs SHALL be ignored.
REQ-020 The first active edge after release SHALL process the current state normally.

Configuration
REQ-021 Macro CLEAR_REDRAW_LINECNT_EN, when defined, SHALL add output `lines_cleared` (4 bits).
- It is registered and loaded in CLEAR with the number of full rows removed (0-8).
- It holds in other states and resets to 0.
REQ-022 Without CLEAR_REDRAW_LINECNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Shared package tetris_pkg SHALL hold:
- state encodings: GEN = 3'b000, MOVE = 3'b001, CLEAR = 3'b011;
- BOARD_ROWS = 8 and BOARD_COLS = 4;
- the four 8-bit piece masks.
REQ-024 The combinational compaction SHALL be a sub-module named row_compactor.
- Inputs: 32-bit board.
- Outputs: 32-bit compacted board and 4-bit full-row count.
REQ-025 clear_redraw SHALL contain only the board/error registers and the GEN/CLEAR muxing.

Verification
REQ-026 Reset, then CLEAR with board_in = 32'hEEEEEE00, then GEN with piece 10 -> board_out EEEEEE00 after CLEAR, EEEEEE46 after GEN; error = 0; MOVE holds EEEEEE46.
REQ-027 CLEAR with 32'hABAFFDCD, then GEN with piece 10 -> ABADCD00, then ABADCD46.
REQ-028 CLEAR with 32'hABADCDFA, then GEN with piece 11 -> ABADCDA0; A & 6 overlaps, so error = 1 and the board stays ABADCDA0.
- A later GEN with piece 00 leaves the board unchanged.
REQ-029 CLEAR with 32'hFFFFFFFF -> board_out 0.
- With CLEAR_REDRAW_LINECNT_EN defined, lines_cleared = 8.
REQ-030 CLEAR with 32'hEEEEEEE0, then GEN with piece 00 -> EEEEEEE6; GEN with piece 01 on EEEEEE00 -> EEEEEE66.
REQ-031 Drive restart_n low asynchronously between edges while error = 1 -> board_out = 0 and error = 0 immediately.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: definitions shared by the Tetris board datapath.
//   - game_state_e : state codes driven by the game controller
//   - BOARD_ROWS / BOARD_COLS / BOARD_W : board geometry
//   - ROW_FULL : value of a completely filled row
//   - PIECE_MASK_* and piece_mask() : spawn footprints over board bits [7:0]
package tetris_pkg;

  typedef enum logic [2:0] {
    GEN   = 3'b000,
    MOVE  = 3'b001,
    CLEAR = 3'b011
  } game_state_e;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 4;
  localparam int BOARD_W    = BOARD_ROWS * BOARD_COLS;

  localparam logic [BOARD_COLS-1:0] ROW_FULL = '1;

  // Spawn footprints covering rows 6-7 (board bits [7:0]).
  localparam logic [7:0] PIECE_MASK_0 = 8'h06;
  localparam logic [7:0] PIECE_MASK_1 = 8'h66;
  localparam logic [7:0] PIECE_MASK_2 = 8'h46;
  localparam logic [7:0] PIECE_MASK_3 = 8'h63;

  function automatic logic [7:0] piece_mask(input logic [1:0] piece);
    logic [7:0] mask;
    case (piece)
      2'b00:   mask = PIECE_MASK_0;
      2'b01:   mask = PIECE_MASK_1;
      2'b10:   mask = PIECE_MASK_2;
      default: mask = PIECE_MASK_3;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/row_compactor.sv
// row_compactor: purely combinational line clear.
// Removes every full row from the board, lets the surviving rows fall toward
// row 0 (bits [31:28]) in their original order, and fills the vacated top
// rows with zeros.
// Ports:
//   board     : input  [31:0] board to compact (row r = bits [31-4r:28-4r])
//   compacted : output [31:0] board with full rows removed
//   full_rows : output [3:0]  number of full rows removed (0-8)
module row_compactor
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  output logic [BOARD_W-1:0] compacted,
  output logic [3:0]         full_rows
);

  // Walk from the top row down to row 0. Each surviving row is inserted at
  // row 0 and everything collected so far slides up one row, so after the
  // walk the survivors sit in rows 0..n-1 in their original order and the
  // zeros that seeded the accumulator occupy the rows above them.
  always_comb begin
    compacted = '0;
    full_rows = '0;
    for (int r = BOARD_ROWS - 1; r >= 0; r--) begin
      if (board[BOARD_COLS*(BOARD_ROWS-1-r) +: BOARD_COLS] == ROW_FULL) begin
        full_rows = full_rows + 4'd1;
      end else begin
        compacted = {board[BOARD_COLS*(BOARD_ROWS-1-r) +: BOARD_COLS],
                     compacted[BOARD_W-1:BOARD_COLS]};
      end
    end
  end

endmodule

// File: rtl/clear_redraw.sv
// clear_redraw: board register for the Tetris controller.
//   CLEAR : load the line-cleared version of board_in
//   GEN   : stamp the selected piece into the spawn zone (rows 6-7), or raise
//           the sticky game-over flag if the spawn zone is already occupied
//   other : hold
// Ports:
//   clka       : clock, all state updates on the rising edge
//   restart_n  : asynchronous active-low reset
//   state      : [2:0] controller state (GEN/MOVE/CLEAR, other codes hold)
//   board_in   : [31:0] landed board snapshot, used in CLEAR
//   curr_piece : [1:0] piece to spawn, used in GEN
//   board_out  : [31:0] registered board
//   error      : registered sticky spawn-collision flag
//   lines_cleared : [3:0] rows removed by the last CLEAR
//                   (only when CLEAR_REDRAW_LINECNT_EN is defined)
module clear_redraw
  import tetris_pkg::*;
(
  input  logic               clka,
  input  logic               restart_n,
  input  logic [2:0]         state,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [1:0]         curr_piece,
  output logic [BOARD_W-1:0] board_out,
  output logic               error
`ifdef CLEAR_REDRAW_LINECNT_EN
  ,
  output logic [3:0]         lines_cleared
`endif
);

  logic [BOARD_W-1:0] board_q;
  logic               error_q;
  logic [BOARD_W-1:0] compacted;
  logic [3:0]         full_rows;
  logic [7:0]         mask;
  logic               collide;

  row_compactor u_compactor (
    .board     (board_in),
    .compacted (compacted),
    .full_rows (full_rows)
  );

  // The spawn collision test only looks at the spawn zone, since the piece
  // masks never reach above bit 7.
  always_comb begin
    mask    = piece_mask(curr_piece);
    collide = (board_q[7:0] & mask) != 8'h00;
  end

  // Board and game-over registers. Once error is set, GEN no longer touches
  // the board, but CLEAR keeps working so the display stays meaningful.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      board_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: board_q <= compacted;
        GEN: begin
          if (collide) begin
            error_q <= 1'b1;
          end else if (!error_q) begin
            board_q[7:0] <= board_q[7:0] | mask;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLEAR_REDRAW_LINECNT_EN
  // Line count from the most recent CLEAR; held in every other state.
  logic [3:0] lines_q;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      lines_q <= '0;
    end else if (state == CLEAR) begin
      lines_q <= full_rows;
    end
  end

  assign lines_cleared = lines_q;
`else
  // Without the line counter the count from the compactor has no consumer.
  logic unused_full_rows;
  assign unused_full_rows = ^full_rows;
`endif

  assign board_out = board_q;
  assign error     = error_q;

endmodule

// File: tb/tb_clear_redraw.sv
// tb_clear_redraw: scoreboard bench for clear_redraw.
// Each driven cycle runs a row-list reference model and queues the expected
// registered outputs; a monitor compares them one cycle later.
// Honours CLEAR_REDRAW_LINECNT_EN for the optional lines_cleared port.
module tb_clear_redraw;

  logic        clka;
  logic        restart_n;
  logic [2:0]  state_in;
  logic [31:0] board_in;
  logic [1:0]  curr_piece;
  logic [31:0] board_out;
  logic        error;
`ifdef CLEAR_REDRAW_LINECNT_EN
  logic [3:0]  lines_cleared;
`endif

  clear_redraw dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .state      (state_in),
    .board_in   (board_in),
    .curr_piece (curr_piece),
    .board_out  (board_out),
    .error      (error)
`ifdef CLEAR_REDRAW_LINECNT_EN
    ,
    .lines_cleared (lines_cleared)
`endif
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct {
    logic [31:0] board;
    logic        err;
    logic [3:0]  lines;
  } exp_t;

  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_board;
  logic        m_err;
  logic [3:0]  m_lines;

  logic [7:0] masks [4] = '{8'h06, 8'h66, 8'h46, 8'h63};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference line clear: collect non-full rows bottom-up in a list, then
  // lay them out from row 0 and pad the rest with empty rows.
  task automatic modelCompact(input logic [31:0] b, output logic [31:0] res,
                              output logic [3:0] n);
    logic [3:0] keep[$];
    logic [3:0] nib;
    for (int r = 0; r < 8; r++) begin
      nib = b[31-4*r -: 4];
      if (nib != 4'hF) keep.push_back(nib);
    end
    res = 32'h0;
    for (int i = 0; i < keep.size(); i++) res[31-4*i -: 4] = keep[i];
    n = 4'(8 - keep.size());
  endtask

  // Drive one cycle of inputs, advance the model, queue the expectation.
  task automatic applyStimulus(input logic [2:0] st, input logic [31:0] bin,
                               input logic [1:0] pc);
    exp_t e;
    logic [31:0] c;
    logic [3:0]  n;
    @(negedge clka);
    state_in   = st;
    board_in   = bin;
    curr_piece = pc;
    if (st == 3'b011) begin
      modelCompact(bin, c, n);
      m_board = c;
      m_lines = n;
    end else if (st == 3'b000) begin
      if ((m_board[7:0] & masks[pc]) != 8'h00) m_err = 1'b1;
      else if (!m_err) m_board[7:0] = m_board[7:0] | masks[pc];
    end
    e.board = m_board;
    e.err   = m_err;
    e.lines = m_lines;
    exp_q.push_back(e);
  endtask

  // Park the inputs on a hold code and wait, bounded, for the monitor to
  // consume every queued expectation.
  task automatic drain();
    int budget;
    @(negedge clka);
    state_in = 3'b001;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clka);
      #2;
      budget--;
    end
    tests_run++;
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Assert reset between clock edges, check it takes effect at once, keep it
  // low across edges with random state inputs, then release on a hold code.
  task automatic doReset();
    drain();
    @(posedge clka);
    #2;
    restart_n = 1'b0;
    #1;
    checkOutput("async_reset_board", board_out, 32'h0);
    checkOutput("async_reset_error", {31'h0, error}, 32'h0);
`ifdef CLEAR_REDRAW_LINECNT_EN
    checkOutput("async_reset_lines", {28'h0, lines_cleared}, 32'h0);
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      state_in   = 3'($urandom_range(0, 7));
      board_in   = $urandom;
      curr_piece = 2'($urandom_range(0, 3));
      @(posedge clka);
      #1;
      checkOutput("in_reset_board", board_out, 32'h0);
      checkOutput("in_reset_error", {31'h0, error}, 32'h0);
    end
    @(negedge clka);
    state_in  = 3'b001;
    restart_n = 1'b1;
    m_board = 32'h0;
    m_err   = 1'b0;
    m_lines = 4'h0;
  endtask

  function automatic logic [31:0] randBoard();
    logic [31:0] b;
    for (int r = 0; r < 8; r++)
      b[31-4*r -: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
    return b;
  endfunction

  // Monitor: one cycle after each driven edge the registered outputs must
  // match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clka);
      #1;
      if (restart_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("board_out", board_out, e.board);
        checkOutput("error", {31'h0, error}, {31'h0, e.err});
`ifdef CLEAR_REDRAW_LINECNT_EN
        checkOutput("lines_cleared", {28'h0, lines_cleared}, {28'h0, e.lines});
`endif
      end
    end
  end

  initial begin
    logic [2:0] st;
    int pick;
    restart_n  = 1'b0;
    state_in   = 3'b001;
    board_in   = 32'h0;
    curr_piece = 2'b00;
    m_board = 32'h0;
    m_err   = 1'b0;
    m_lines = 4'h0;
    #3;
    checkOutput("power_on_board", board_out, 32'h0);
    checkOutput("power_on_error", {31'h0, error}, 32'h0);
    @(negedge clka);
    restart_n = 1'b1;

    // Clear with no full rows, spawn, then hold.
    applyStimulus(3'b011, 32'hEEEEEE00, 2'b00);
    applyStimulus(3'b000, 32'h0, 2'b10);
    applyStimulus(3'b001, 32'h0, 2'b00);
    // Two adjacent full rows in the middle.
    applyStimulus(3'b011, 32'hABAFFDCD, 2'b00);
    applyStimulus(3'b000, 32'h0, 2'b10);
    // Spawn collision sets error; a later GEN leaves the board alone.
    applyStimulus(3'b011, 32'hABADCDFA, 2'b00);
    applyStimulus(3'b000, 32'h0, 2'b11);
    applyStimulus(3'b000, 32'h0, 2'b00);
    // Undefined codes hold while error is set, CLEAR still works.
    applyStimulus(3'b110, 32'h12345678, 2'b01);
    applyStimulus(3'b011, 32'hFFFF1234, 2'b00);
    doReset();

    // Every row full, then the two remaining piece shapes.
    applyStimulus(3'b011, 32'hFFFFFFFF, 2'b00);
    applyStimulus(3'b011, 32'hEEEEEEE0, 2'b00);
    applyStimulus(3'b000, 32'h0, 2'b00);
    applyStimulus(3'b011, 32'hEEEEEE00, 2'b00);
    applyStimulus(3'b000, 32'h0, 2'b01);
    applyStimulus(3'b011, 32'hF0F0F0F0, 2'b00);
    doReset();

    // Randomized traffic with periodic resets.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4)      st = 3'b000;
      else if (pick < 7) st = 3'b011;
      else if (pick < 9) st = 3'b001;
      else               st = 3'($urandom_range(4, 7));
      applyStimulus(st, randBoard(), 2'($urandom_range(0, 3)));
      if (i % 40 == 39) doReset();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
